// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_if
//  Purpose  : Bundles the requester-side and transmitter-side handshakes of
//             uart_tx_arbiter into one interface.
//  Signals  : i_req_valid/i_req_data/i_req_last  requester byte stream
//             o_req_ready                        per-requester accept
//             o_tx_data/o_tx_req/i_tx_cts        transmitter byte handshake
//             o_grant/o_busy/o_msg_count         status
//             o_timeout                          stalled-message abort pulse
//  Modports : slave  - the arbiter (drives the o_* signals)
//             master - the surrounding logic (drives the i_* signals)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [7:0]           o_tx_data;
  logic                 o_tx_req;
  logic                 i_tx_cts;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_busy;
  logic [15:0]          o_msg_count;
  logic                 o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_cts,
    output o_req_ready, o_tx_data, o_tx_req, o_grant, o_busy, o_msg_count, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_cts,
    input  o_req_ready, o_tx_data, o_tx_req, o_grant, o_busy, o_msg_count, o_timeout
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one byte transmitter between NUM_REQ message sources.
//             Round-robin grant, held for a whole message so messages never
//             interleave. A one-byte holding register decouples the
//             requester handshake from the transmitter handshake.
//  Ports    : clock  - system clock
//             rst_n  - asynchronous, active-low reset
//             bus    - uart_tx_arbiter_if.slave (requester + transmitter side)
//  Params   : NUM_REQ        - requester count, 1..8
//             TIMEOUT_CYCLES - FETCH stall limit (>= 2), used with the macro
//  Option   : define UART_ARB_TIMEOUT_EN to abort a message whose owner stops
//             presenting bytes for TIMEOUT_CYCLES cycles (o_timeout pulses).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time guards on the configuration.
  if ((NUM_REQ < 1) || (NUM_REQ > 8)) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [IDX_W-1:0]   ptr_q,       ptr_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic               hold_last_q, hold_last_d;
  logic [15:0]        msg_count_q, msg_count_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
  logic               timeout_q,   timeout_d;
`endif

  // --------------------------------------------------------------------------
  // Round-robin search. Doubling the valid vector and shifting by ptr puts
  // requester (ptr+i) mod NUM_REQ at bit i, so the lowest set bit wins.
  // --------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_rot;
  logic                 w_any_valid;
  logic [IDX_W-1:0]     w_winner;

  always_comb begin
    w_dbl       = {bus.i_req_valid, bus.i_req_valid};
    w_rot       = w_dbl >> ptr_q;
    w_any_valid = 1'b0;
    w_winner    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any_valid = 1'b1;
        w_winner    = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Granted requester's stream, and the pointer value one past the owner.
  // Only the owner's valid/data/last are ever looked at.
  // --------------------------------------------------------------------------
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [7:0]       w_sel_data;
  logic [IDX_W-1:0] w_next_ptr;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    w_next_ptr  = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        w_sel_valid = bus.i_req_valid[k];
        w_sel_last  = bus.i_req_last[k];
        w_sel_data  = bus.i_req_data[8*k +: 8];
        w_next_ptr  = IDX_W'((k + 1) % NUM_REQ);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    msg_count_d = msg_count_q;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (w_any_valid) begin
          state_d  = ST_FETCH;
          grant_d  = NUM_REQ'(1) << w_winner;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end

      ST_FETCH: begin
        if (w_sel_valid) begin
          hold_data_d = w_sel_data;
          hold_last_d = w_sel_last;
          state_d     = ST_SEND;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Owner went quiet too long: drop the message uncounted.
          state_d   = ST_IDLE;
          grant_d   = '0;
          ptr_d     = w_next_ptr;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      ST_SEND: begin
        if (bus.i_tx_cts) begin
          if (hold_last_q) begin
            state_d     = ST_IDLE;
            grant_d     = '0;
            ptr_d       = w_next_ptr;
            msg_count_d = msg_count_q + 16'd1;
          end else begin
            state_d  = ST_FETCH;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
      msg_count_q <= 16'd0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      msg_count_q <= msg_count_d;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are decoded straight from registers.
  // --------------------------------------------------------------------------
  assign bus.o_tx_req    = (state_q == ST_SEND);
  assign bus.o_tx_data   = hold_data_q;
  assign bus.o_req_ready = (state_q == ST_FETCH) ? grant_q : '0;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_msg_count = msg_count_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.o_timeout   = timeout_q;
`else
  assign bus.o_timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter. A transaction-level
//             model (owner / held byte / pointer / message count) predicts
//             every output each cycle; directed scenarios add literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int TIMEOUT_CYCLES = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Requester sources: each queue entry is {last, data}; valid = non-empty.
  // --------------------------------------------------------------------------
  logic [8:0]         q0[$];
  logic [8:0]         q1[$];
  logic [NUM_REQ-1:0] drv_acc;

  task automatic drive_sources();
    bus.i_req_valid[0]   = (q0.size() != 0);
    bus.i_req_last[0]    = (q0.size() != 0) ? q0[0][8]   : 1'b0;
    bus.i_req_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    bus.i_req_valid[1]   = (q1.size() != 0);
    bus.i_req_last[1]    = (q1.size() != 0) ? q1[0][8]   : 1'b0;
    bus.i_req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
  endtask

  always @(posedge clock) begin
    drv_acc = bus.o_req_ready & bus.i_req_valid;
    #1;
    if (drv_acc[0] && q0.size() != 0) void'(q0.pop_front());
    if (drv_acc[1] && q1.size() != 0) void'(q1.pop_front());
    drive_sources();
  end

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int          m_owner;   // -1 when no message owns the line
  bit          m_have;    // a byte is waiting for the transmitter
  logic [7:0]  m_byte;
  bit          m_last;
  int          m_ptr;
  logic [15:0] m_count;
  int          m_stall;
  bit          m_to;
  logic [7:0]  dut_log[$];

  function automatic void model_reset();
    m_owner = -1; m_have = 1'b0; m_byte = 8'h00; m_last = 1'b0;
    m_ptr = 0; m_count = 16'd0; m_stall = 0; m_to = 1'b0;
  endfunction

  function automatic void model_step();
    int k;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = (m_ptr + i) % NUM_REQ;
        if (m_owner < 0 && bus.i_req_valid[k]) begin
          m_owner = k;
          m_stall = 0;
        end
      end
    end else if (!m_have) begin
      if (bus.i_req_valid[m_owner]) begin
        m_have = 1'b1;
        m_byte = bus.i_req_data[m_owner*8 +: 8];
        m_last = bus.i_req_last[m_owner];
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
        m_stall++;
        if (m_stall == TIMEOUT_CYCLES) begin
          m_to    = 1'b1;
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end
`endif
      end
    end else if (bus.i_tx_cts) begin
      m_have = 1'b0;
      if (m_last) begin
        m_count = m_count + 16'd1;
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end else begin
        m_stall = 0;
      end
    end
  endfunction

  initial model_reset();

  // Compare process: outputs sampled mid-cycle against the model.
  logic [NUM_REQ-1:0] exp_grant;
  always @(negedge clock) begin
    if (!rst_n) begin
      model_reset();
      if (mon_en)
        chk("reset_outputs",
            {bus.o_req_ready, bus.o_tx_data, bus.o_tx_req, bus.o_grant,
             bus.o_busy, bus.o_msg_count, bus.o_timeout}, 32'd0);
    end else if (mon_en) begin
      exp_grant = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
      chk("grant",     bus.o_grant,     exp_grant);
      chk("busy",      bus.o_busy,      m_owner >= 0);
      chk("tx_req",    bus.o_tx_req,    m_have);
      chk("tx_data",   bus.o_tx_data,   m_byte);
      chk("req_ready", bus.o_req_ready, (m_owner >= 0 && !m_have) ? exp_grant : '0);
      chk("msg_count", bus.o_msg_count, m_count);
      chk("timeout",   bus.o_timeout,   m_to);
      if (bus.o_tx_req && bus.i_tx_cts) dut_log.push_back(bus.o_tx_data);
      model_step();
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget, input string name);
    int n = 0;
    while (bus.o_msg_count !== target && n < budget) begin
      tick();
      n++;
    end
    chk(name, bus.o_msg_count, target);
  endtask

  task automatic wait_grant(input logic [NUM_REQ-1:0] target, input int budget, input string name);
    int n = 0;
    while (bus.o_grant !== target && n < budget) begin
      tick();
      n++;
    end
    chk(name, bus.o_grant, target);
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, (dut_log.size() >= exp.size()), 1'b1);
    if (dut_log.size() >= exp.size())
      for (int i = 0; i < exp.size(); i++) chk(name, dut_log[i], exp[i]);
  endtask

  task automatic pulse_reset();
    tick();
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    drive_sources();
    #1;
    chk("async_reset_outputs",
        {bus.o_req_ready, bus.o_tx_data, bus.o_tx_req, bus.o_grant,
         bus.o_busy, bus.o_msg_count, bus.o_timeout}, 32'd0);
    @(negedge clock);
    tick();
    rst_n = 1'b1;
    dut_log.delete();
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  int pulses;

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_tx_cts    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle after reset
    repeat (10) tick();
    chk("t1_busy",  bus.o_busy,      1'b0);
    chk("t1_grant", bus.o_grant,     2'b00);
    chk("t1_txreq", bus.o_tx_req,    1'b0);
    chk("t1_count", bus.o_msg_count, 16'd0);

    // Single three-byte message from requester 0
    bus.i_tx_cts = 1'b1;
    dut_log.delete();
    q0.push_back({1'b0, 8'h48});
    q0.push_back({1'b0, 8'h69});
    q0.push_back({1'b1, 8'h0A});
    wait_count(16'd1, 40, "t2_count");
    check_log("t2_bytes", '{8'h48, 8'h69, 8'h0A});

    // Pointer now at 1: simultaneous one-byte messages go 1 then 0
    dut_log.delete();
    q0.push_back({1'b1, 8'hC0});
    q1.push_back({1'b1, 8'hC1});
    wait_count(16'd3, 40, "t2b_count");
    check_log("t2b_order", '{8'hC1, 8'hC0});

    // Both requesters always valid, two-byte messages
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b0, 8'hA0});
      q0.push_back({1'b1, 8'hA1});
      q1.push_back({1'b0, 8'hB0});
      q1.push_back({1'b1, 8'hB1});
    end
    wait_count(16'd3, 80, "t3_count");
    check_log("t3_order", '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA0, 8'hA1});

    // Transmitter stalled for 50 cycles
    pulse_reset();
    bus.i_tx_cts = 1'b0;
    q0.push_back({1'b1, 8'h55});
    begin
      int n = 0;
      while (bus.o_tx_req !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
    end
    chk("t4_txreq_up", bus.o_tx_req, 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t4_hold_req",   bus.o_tx_req,    1'b1);
      chk("t4_hold_data",  bus.o_tx_data,   8'h55);
      chk("t4_hold_ready", bus.o_req_ready, 2'b00);
    end
    bus.i_tx_cts = 1'b1;
    tick();
    chk("t4_txreq_done", bus.o_tx_req,    1'b0);
    chk("t4_count",      bus.o_msg_count, 16'd1);

    // Reset in the middle of a message (pointer is 1 going in)
    dut_log.delete();
    q0.push_back({1'b0, 8'hD0});
    q0.push_back({1'b0, 8'hD1});
    q0.push_back({1'b1, 8'hD2});
    begin
      int n = 0;
      while (dut_log.size() == 0 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t5_first_byte", dut_log.size(), 32'd1);
    pulse_reset();
    q1.push_back({1'b1, 8'hE1});
    q0.push_back({1'b1, 8'hE0});
    wait_count(16'd2, 40, "t5_count");
    check_log("t5_order", '{8'hE0, 8'hE1});

    // Owner stalls mid-message while requester 0 waits
    dut_log.delete();
    q1.push_back({1'b0, 8'hF1});
    wait_grant(2'b10, 20, "t6_grant1");
    q0.push_back({1'b1, 8'hF0});
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.o_timeout === 1'b1) pulses++;
    end
`ifdef UART_ARB_TIMEOUT_EN
    chk("t6_pulses", pulses, 32'd1);
    wait_count(16'd3, 40, "t6_count");
    check_log("t6_order", '{8'hF1, 8'hF0});
`else
    chk("t6_pulses", pulses, 32'd0);
    chk("t6_still_granted", bus.o_grant, 2'b10);
    chk("t6_count_held", bus.o_msg_count, 16'd2);
    q1.push_back({1'b1, 8'hF2});
    wait_count(16'd4, 60, "t6_count");
    check_log("t6_order", '{8'hF1, 8'hF2, 8'hF0});
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
